attempt_flow_ctrl: RTL and testbench
====================================

# attempt_flow_ctrl

Game-flow controller that sequences each run of the obstacle game and owns the attempt/score datapath that feeds the two-digit seven-segment display. It turns player start, death and victory events into a four-state run sequence (idle, play, death hold, victory show). It keeps a saturating two-digit BCD attempt count and the best (fewest-deaths) winning run, and selects which value is shown. It sits between the level logic / jump input and the seven-segment decoders, and gates the game-clock-driven object counters through `game_run` and `respawn`.

## Interface
- `HOLD_TICKS`, 24: ticks spent in death hold before respawn (≥1)
- `BLINK_TICKS`, 12: ticks per blink phase on the victory screen (≥1)
- `SHOW_TICKS`, 96: ticks the victory screen is held before returning to idle (≥1)

- `clk` in 1: system clock (50 MHz domain); the only clock
- `reset_n` in 1: reset, asynchronous and active-low
- `tick` in 1: one-`clk` strobe at game rate (24 Hz); all durations count ticks
- `start` in 1: synchronized jump/start key, level
- `death` in 1: player-death level from level logic
- `win` in 1: victory level from level logic
- `state` out 2: 0 IDLE, 1 PLAY, 2 DEAD, 3 WIN
- `game_run` out 1: high only in PLAY
- `respawn` out 1: one-`clk` pulse on every entry to PLAY
- `att_bcd` out 8: {tens, ones} BCD attempt (death) count of current run
- `best_bcd` out 8: {tens, ones} BCD best winning attempt count
- `best_valid` out 1: a best score has been recorded
- `disp_bcd` out 8: value routed to HEX1/HEX0
- `disp_blank` out 1: display segments forced off
- `overflow` out 1: sticky; attempt count saturated at 99

## Operation
- Edge detect: `start`, `death` and `win` each have a registered previous value, updated every cycle in every state and reset to 0. A "rise" is input=1 with prev=0. A level that is already high when PLAY is entered does not count.
- IDLE: `game_run`=0, `disp_bcd`=`att_bcd`. A `start` rise moves to PLAY and pulses `respawn`.
- PLAY: `game_run`=1.
  - `win` rise moves to WIN.
  - `death` rise moves to DEAD and increments `att_bcd`.
  - If both rise in the same cycle, `win` has priority and there is no increment.
  - `start` is ignored.
- DEAD: `game_run`=0. Counts ticks. On the cycle with `tick`=1 and count = HOLD_TICKS−1, moves to PLAY and pulses `respawn`. `death` and `start` are ignored; a `win` rise is ignored.
- WIN, entry edge: if `best_valid`=0 or `att_bcd` < `best_bcd`, load `best_bcd`←`att_bcd` and set `best_valid`. The comparison is an unsigned 8-bit compare, which is valid for BCD. Ties do not update.
- WIN, display: `disp_bcd`=`best_bcd`. `disp_blank` starts at 0 and toggles on every BLINK_TICKS-th tick.
- WIN, exit: after SHOW_TICKS ticks, moves to IDLE. On that same edge: `att_bcd`←00, `overflow`←0, `disp_blank`←0. All inputs are ignored in WIN.
- BCD increment:
  - ones 0–8: +1.
  - ones 9: ones←0, tens+1.
  - at 99: hold at 99 and set `overflow`.
  - Digits are never outside 0–9.
- Tick counter: a single counter, cleared on every state transition, advanced only when `tick`=1. Width is ceil(log2(max param)) + 1.
- `disp_blank`=0 outside WIN.

## Timing
- All outputs are registered. Updates take effect at the clock edge of the detection cycle and are visible in the next cycle (latency 1 `clk` from input rise).
- `respawn` is high exactly during the first PLAY cycle and low otherwise.
- DEAD lasts exactly HOLD_TICKS ticks. WIN lasts exactly SHOW_TICKS ticks.
- Reset values:
  - `state`=IDLE, `game_run`=0, `respawn`=0
  - `att_bcd`=0x00, `best_bcd`=0x99, `best_valid`=0
  - `disp_bcd`=0x00, `disp_blank`=0, `overflow`=0
  - all prev registers 0, tick counter 0
- Reset asserted mid-run (any state) returns immediately to these values, including clearing `best`.

## Test plan
- Reset, then `start` rise → `state`=1 next cycle; `respawn` high for exactly 1 cycle; `game_run`=1; `att_bcd`=0x00.
- In PLAY, 3 separate `death` rises, each followed by 24 ticks → `att_bcd`=0x03; each DEAD lasts 24 ticks; `respawn` pulses 3 times. `death` held high across a respawn is not counted again.
- Force 100 deaths → `att_bcd` sequence passes through 0x09→0x10 and 0x89→0x90, holds at 0x99; `overflow`=1 after the 100th death.
- Win with `att_bcd`=0x05 (first win) → `best_bcd`=0x05 and `best_valid`=1; `disp_bcd`=0x05; `disp_blank` toggles every 12 ticks; IDLE after 96 ticks with `att_bcd`=0x00. A later win at 0x07 leaves best at 0x05; a later win at 0x02 sets best to 0x02.
- `death` and `win` rise in the same cycle in PLAY → `state`=3 and `att_bcd` unchanged.
- `reset_n` low during WIN with best recorded → all outputs at reset values asynchronously: `best_bcd`=0x99, `best_valid`=0.

Source files
------------

// File: rtl/attempt_flow_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attempt_flow_ctrl_if
// Event inputs and display/status outputs of the game-flow controller.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface attempt_flow_ctrl_if;
  logic       tick;
  logic       start;
  logic       death;
  logic       win;
  logic [1:0] state;
  logic       game_run;
  logic       respawn;
  logic [7:0] att_bcd;
  logic [7:0] best_bcd;
  logic       best_valid;
  logic [7:0] disp_bcd;
  logic       disp_blank;
  logic       overflow;

  modport master (
    output tick, start, death, win,
    input  state, game_run, respawn, att_bcd, best_bcd, best_valid,
           disp_bcd, disp_blank, overflow
  );

  modport slave (
    input  tick, start, death, win,
    output state, game_run, respawn, att_bcd, best_bcd, best_valid,
           disp_bcd, disp_blank, overflow
  );
endinterface
`default_nettype wire

// File: rtl/attempt_flow_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attempt_flow_ctrl
// Run sequencer (idle/play/dead/win) with BCD attempt count and best score.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module attempt_flow_ctrl #(
  parameter int HOLD_TICKS  = 24,
  parameter int BLINK_TICKS = 12,
  parameter int SHOW_TICKS  = 96
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  attempt_flow_ctrl_if.slave bus
);

  localparam int c_MAX_A     = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
  localparam int c_MAX_TICKS = (c_MAX_A > SHOW_TICKS) ? c_MAX_A : SHOW_TICKS;
  localparam int c_CNT_W     = $clog2(c_MAX_TICKS) + 1;

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_SHOW_LAST = c_CNT_W'(SHOW_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_BLINK     = c_CNT_W'(BLINK_TICKS);
  localparam logic [7:0]         c_BCD_MAX   = 8'h99;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_WIN  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic                 r_death_q;
  logic                 r_win_q;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_CNT_W-1:0]   w_cnt_inc;
  logic                 r_game_run;
  logic                 r_respawn;
  logic [7:0]           r_att;
  logic [7:0]           w_att_nxt;
  logic [7:0]           r_best;
  logic [7:0]           w_best_nxt;
  logic                 r_best_valid;
  logic                 w_best_valid_nxt;
  logic [7:0]           r_disp;
  logic                 r_blank;
  logic                 w_blank_nxt;
  logic                 r_overflow;
  logic                 w_overflow_nxt;
  logic                 w_start_rise;
  logic                 w_death_rise;
  logic                 w_win_rise;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] == 4'd9) begin
      res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_death_rise = bus.death & ~r_death_q;
  assign w_win_rise   = bus.win   & ~r_win_q;
  assign w_cnt_inc    = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_att_nxt        = r_att;
    w_best_nxt       = r_best;
    w_best_valid_nxt = r_best_valid;
    w_overflow_nxt   = r_overflow;
    w_blank_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // A simultaneous win outranks the death and costs no attempt.
        if (w_win_rise) begin
          w_state_nxt = S_WIN;
          if (!r_best_valid || (r_att < r_best)) begin
            w_best_nxt       = r_att;
            w_best_valid_nxt = 1'b1;
          end
        end else if (w_death_rise) begin
          w_state_nxt = S_DEAD;
          if (r_att == c_BCD_MAX) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_att_nxt = bcd_inc(r_att);
          end
        end
      end
      S_DEAD: begin
        if (bus.tick && (r_cnt == c_HOLD_LAST)) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_WIN: begin
        w_blank_nxt = r_blank;
        if (bus.tick) begin
          if (r_cnt == c_SHOW_LAST) begin
            w_state_nxt    = S_IDLE;
            w_att_nxt      = 8'h00;
            w_overflow_nxt = 1'b0;
            w_blank_nxt    = 1'b0;
          end else if ((w_cnt_inc % c_BLINK) == '0) begin
            w_blank_nxt = ~r_blank;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (bus.tick && ((r_state == S_DEAD) || (r_state == S_WIN))) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q    <= 1'b0;
      r_death_q    <= 1'b0;
      r_win_q      <= 1'b0;
      r_cnt        <= '0;
      r_game_run   <= 1'b0;
      r_respawn    <= 1'b0;
      r_att        <= 8'h00;
      r_best       <= 8'h99;
      r_best_valid <= 1'b0;
      r_disp       <= 8'h00;
      r_blank      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_start_q    <= bus.start;
      r_death_q    <= bus.death;
      r_win_q      <= bus.win;
      r_cnt        <= w_cnt_nxt;
      r_game_run   <= (w_state_nxt == S_PLAY);
      r_respawn    <= (w_state_nxt == S_PLAY) && (r_state != S_PLAY);
      r_att        <= w_att_nxt;
      r_best       <= w_best_nxt;
      r_best_valid <= w_best_valid_nxt;
      r_disp       <= (w_state_nxt == S_WIN) ? w_best_nxt : w_att_nxt;
      r_blank      <= w_blank_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

  assign bus.state      = r_state;
  assign bus.game_run   = r_game_run;
  assign bus.respawn    = r_respawn;
  assign bus.att_bcd    = r_att;
  assign bus.best_bcd   = r_best;
  assign bus.best_valid = r_best_valid;
  assign bus.disp_bcd   = r_disp;
  assign bus.disp_blank = r_blank;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_attempt_flow_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_attempt_flow_ctrl
// Scoreboard bench: stimulus queues expected records, monitor compares them.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_attempt_flow_ctrl;

  localparam int HOLD  = 24;
  localparam int BLINK = 12;
  localparam int SHOW  = 96;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  attempt_flow_ctrl_if bus ();

  attempt_flow_ctrl #(
    .HOLD_TICKS  (HOLD),
    .BLINK_TICKS (BLINK),
    .SHOW_TICKS  (SHOW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  // -1 in any field means "not checked"
  typedef struct {
    string name;
    int st, att, best, bv, disp, ov, resp, ticks, blank, run;
  } exp_t;

  exp_t q_st[$];
  exp_t q_snap[$];
  int   q_blk_tick[$];
  int   q_blk_val[$];

  int   checks      = 0;
  int   errors      = 0;
  int   n_resp_exp  = 0;
  int   n_resp_seen = 0;
  int   traw        = 0;
  int   base        = 0;
  logic done        = 1'b0;
  logic [1:0] prev_st    = 2'd0;
  logic       prev_blank = 1'b0;
  exp_t e_cur;
  int   et, ev;

  int m_att  = 0;
  int m_best = 99;
  int m_bv   = 0;
  int m_ov   = 0;

  function automatic int tobcd(input int v);
    return ((v / 10) * 16) + (v % 10);
  endfunction

  function automatic exp_t mk(input string n, input int st, input int att, input int best,
                              input int bv, input int disp, input int ov, input int resp,
                              input int ticks, input int blank, input int run);
    exp_t e;
    e.name = n; e.st = st; e.att = att; e.best = best; e.bv = bv; e.disp = disp;
    e.ov = ov; e.resp = resp; e.ticks = ticks; e.blank = blank; e.run = run;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e);
    if (e.st    >= 0) chk({e.name, ".state"},      32'(bus.state),      e.st);
    if (e.att   >= 0) chk({e.name, ".att_bcd"},    32'(bus.att_bcd),    e.att);
    if (e.best  >= 0) chk({e.name, ".best_bcd"},   32'(bus.best_bcd),   e.best);
    if (e.bv    >= 0) chk({e.name, ".best_valid"}, 32'(bus.best_valid), e.bv);
    if (e.disp  >= 0) chk({e.name, ".disp_bcd"},   32'(bus.disp_bcd),   e.disp);
    if (e.ov    >= 0) chk({e.name, ".overflow"},   32'(bus.overflow),   e.ov);
    if (e.resp  >= 0) chk({e.name, ".respawn"},    32'(bus.respawn),    e.resp);
    if (e.ticks >= 0) chk({e.name, ".ticks"},      32'(traw - base),    e.ticks);
    if (e.blank >= 0) chk({e.name, ".disp_blank"}, 32'(bus.disp_blank), e.blank);
    if (e.run   >= 0) chk({e.name, ".game_run"},   32'(bus.game_run),   e.run);
  endtask

  always @(posedge clk) begin
    if (bus.tick === 1'b1) traw++;
  end

  // Monitor: every state change or blink toggle pops one expected record.
  always @(negedge clk) begin
    if (q_snap.size() > 0) begin
      e_cur = q_snap.pop_front();
      cmp(e_cur);
    end
    if (!reset_n) begin
      prev_st    = bus.state;
      prev_blank = bus.disp_blank;
      base       = traw;
    end else begin
      if (bus.respawn === 1'b1) n_resp_seen++;
      if (bus.disp_blank !== prev_blank) begin
        if (q_blk_val.size() == 0) begin
          checks++; errors++;
          $display("FAIL blink_unexpected actual=%0b required=no_toggle", bus.disp_blank);
        end else begin
          et = q_blk_tick.pop_front();
          ev = q_blk_val.pop_front();
          chk("blink.value", 32'(bus.disp_blank), ev);
          chk("blink.tick",  32'(traw - base),    et);
        end
        prev_blank = bus.disp_blank;
      end
      if (bus.state !== prev_st) begin
        if (q_st.size() == 0) begin
          checks++; errors++;
          $display("FAIL state_unexpected actual=%0d required=no_change", bus.state);
        end else begin
          e_cur = q_st.pop_front();
          cmp(e_cur);
        end
        base    = traw;
        prev_st = bus.state;
      end
    end
    if (done) begin
      chk("respawn_count", 32'(n_resp_seen), n_resp_exp);
      chk("state_queue_left", 32'(q_st.size()), 0);
      chk("blink_queue_left", 32'(q_blk_val.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic give_ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1; cyc(1);
      bus.tick = 1'b0; cyc(1);
    end
  endtask

  task automatic do_start();
    n_resp_exp++;
    q_st.push_back(mk("start", 1, tobcd(m_att), tobcd(m_best), m_bv, -1, m_ov, 1, -1, 0, 1));
    bus.start = 1'b1; cyc(3);
    bus.start = 1'b0; cyc(1);
  endtask

  // death stays high across the whole hold and beyond the respawn
  task automatic do_death();
    if (m_att == 99) m_ov = 1;
    else             m_att++;
    q_st.push_back(mk("death", 2, tobcd(m_att), tobcd(m_best), m_bv, -1, m_ov, 0, -1, 0, 0));
    n_resp_exp++;
    q_st.push_back(mk("respawn", 1, tobcd(m_att), tobcd(m_best), m_bv, -1, m_ov, 1, HOLD, 0, 1));
    bus.death = 1'b1; cyc(1);
    give_ticks(HOLD);
    cyc(2);
    bus.death = 1'b0; cyc(1);
  endtask

  task automatic do_win(input bit full, input bit with_death);
    if ((m_bv == 0) || (m_att < m_best)) begin
      m_best = m_att;
      m_bv   = 1;
    end
    q_st.push_back(mk("win", 3, tobcd(m_att), tobcd(m_best), m_bv, tobcd(m_best), m_ov, 0, -1, 0, 0));
    bus.win = 1'b1;
    if (with_death) bus.death = 1'b1;
    cyc(1);
    bus.win = 1'b0; bus.death = 1'b0;
    if (full) begin
      for (int k = 1; k <= SHOW / BLINK; k++) begin
        q_blk_tick.push_back(k * BLINK);
        q_blk_val.push_back(k % 2);
      end
      m_att = 0; m_ov = 0;
      q_st.push_back(mk("show_end", 0, 'h00, tobcd(m_best), m_bv, 'h00, 0, 0, SHOW, 0, 0));
      give_ticks(SHOW);
      cyc(2);
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.death = 1'b0; bus.win = 1'b0;
    q_snap.push_back(mk("reset", 0, 'h00, 'h99, 0, 'h00, 0, 0, -1, 0, 0));
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // run 1: five deaths then first win at 05
    do_start();
    for (int i = 0; i < 3; i++) do_death();
    q_snap.push_back(mk("after3", 1, 'h03, 'h99, 0, -1, 0, 0, -1, 0, 1));
    cyc(2);
    for (int i = 0; i < 2; i++) do_death();
    do_win(1'b1, 1'b0);

    // run 2: win at 07 keeps best 05
    do_start();
    for (int i = 0; i < 7; i++) do_death();
    do_win(1'b1, 1'b0);
    q_snap.push_back(mk("best_kept", 0, 'h00, 'h05, 1, 'h00, 0, 0, -1, 0, 0));
    cyc(2);

    // run 3: win at 02 replaces best
    do_start();
    for (int i = 0; i < 2; i++) do_death();
    do_win(1'b1, 1'b0);
    q_snap.push_back(mk("best_new", 0, 'h00, 'h02, 1, 'h00, 0, 0, -1, 0, 0));
    cyc(2);

    // run 4: death and win rise together
    do_start();
    do_win(1'b1, 1'b1);

    // run 5: saturate at 99, then reset asynchronously inside WIN
    do_start();
    for (int i = 0; i < 100; i++) do_death();
    q_snap.push_back(mk("saturated", 1, 'h99, 'h00, 1, -1, 1, 0, -1, 0, 1));
    cyc(2);
    do_win(1'b0, 1'b0);
    give_ticks(5);
    reset_n = 1'b0;
    q_snap.push_back(mk("async_reset", 0, 'h00, 'h99, 0, 'h00, 0, 0, -1, 0, 0));
    m_att = 0; m_best = 99; m_bv = 0; m_ov = 0;
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    done = 1'b1;
  end

  initial begin
    #10000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
